fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/fetch_ctrl_fsm.sv | 74 +++++++
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the fetch pipeline
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_STEP          = 4;
  localparam int unsigned IMEM_BYTES       = 256;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_fsm.sv
// rtl/fetch_ctrl_fsm.sv - fetch sequencing FSM: RUN, DRAIN, HALTED plus drain counter
module fetch_ctrl_fsm
  import pipeline_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic branch_taken,
  input  logic at_end,
  output logic do_fetch,
  output logic do_bubble,
  output logic do_redirect,
  output logic done
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN_CYCLES);

  fetch_state_e   state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    do_fetch    = 1'b0;
    do_bubble   = 1'b0;
    do_redirect = 1'b0;
    // HALTED ignores every request; only reset leaves it
    if (state_q != HALTED) begin
      if (branch_taken) begin
        do_redirect = 1'b1;
        state_d     = RUN;
        cnt_d       = '0;
      end else if (!stall) begin
        if (state_q == RUN) begin
          if (!at_end) begin
            do_fetch = 1'b1;
          end else begin
            do_bubble = 1'b1;
            state_d   = DRAIN;
            cnt_d     = DRAIN_INIT;
          end
        end else begin
          do_bubble = 1'b1;
          if (cnt_q <= CW'(1)) begin
            state_d = HALTED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
    end
    done_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, ROM addressing and IF/ID register
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] NOP_WORD     = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [8:0]  prog_len,
  input  logic [31:0] imem_instr,
  output logic [7:0]  imem_addr,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        done,
  output logic [15:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic        at_end, do_fetch, do_bubble, do_redirect;

  assign at_end = (pc_q >= {23'd0, prog_len});

  fetch_ctrl_fsm #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .branch_taken(branch_taken),
    .at_end      (at_end),
    .do_fetch    (do_fetch),
    .do_bubble   (do_bubble),
    .do_redirect (do_redirect),
    .done        (done)
  );

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (do_fetch) begin
      pc_d    = pc_q + 32'(PC_STEP);
      instr_d = imem_instr;
      ifpc_d  = pc_q;
      valid_d = 1'b1;
      cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end else if (do_bubble) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (do_redirect) begin
      pc_d    = {branch_target[31:2], 2'b00};
      instr_d = NOP_WORD;
      ifpc_d  = pc_q;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= NOP_WORD;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_out      = pc_q;
  assign imem_addr   = pc_q[7:0];
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage against a cycle-level program model
module tb_fetch_stage;

  localparam int          DRAIN = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [8:0]  prog_len = 9'd16;
  logic [31:0] imem_instr;
  logic [7:0]  imem_addr;
  logic [31:0] pc_out, if_id_instr, if_id_pc;
  logic        if_id_valid, done;
  logic [15:0] fetch_count;

  logic [31:0] rom [64];
  assign imem_instr = rom[imem_addr[7:2]];

  always #5 clk = ~clk;

  fetch_stage #(.DRAIN_CYCLES(DRAIN), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .prog_len(prog_len), .imem_instr(imem_instr),
    .imem_addr(imem_addr), .pc_out(pc_out), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .done(done),
    .fetch_count(fetch_count)
  );

  typedef struct {
    logic [31:0] pc, instr, ifpc;
    logic        valid, done;
    logic [15:0] cnt;
  } snap_t;

  snap_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // model: a program of prog_len bytes is walked 4 bytes at a time, then DRAIN bubbles
  logic [31:0] m_pc, m_instr, m_ifpc;
  bit          m_valid, m_halted, m_draining;
  int          m_left, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, expv);
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = NOP; m_ifpc = 0; m_valid = 0;
    m_halted = 0; m_draining = 0; m_left = 0; m_cnt = 0;
  endtask

  task automatic drive(input bit st, input bit br, input logic [31:0] tgt);
    snap_t s;
    stall = st; branch_taken = br; branch_target = tgt;
    if (!m_halted) begin
      if (br) begin
        m_ifpc = m_pc; m_pc = tgt & ~32'd3; m_instr = NOP; m_valid = 0;
        m_draining = 0; m_left = 0;
      end else if (!st) begin
        if (m_draining) begin
          m_instr = NOP; m_valid = 0; m_left--;
          if (m_left == 0) begin m_halted = 1; m_draining = 0; end
        end else if (m_pc < 32'(prog_len)) begin
          m_instr = rom[m_pc[7:2]]; m_ifpc = m_pc; m_valid = 1; m_pc += 4;
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_instr = NOP; m_valid = 0; m_draining = 1; m_left = DRAIN;
        end
      end
    end
    s.pc = m_pc; s.instr = m_instr; s.ifpc = m_ifpc; s.valid = m_valid;
    s.done = m_halted; s.cnt = 16'(m_cnt);
    exp_q.push_back(s);
  endtask

  // async reset pulse between edges; outputs must clear before any edge
  task automatic do_reset(input logic [8:0] plen);
    @(negedge clk);
    prog_len = plen;
    reset = 1'b1;
    #1;
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_ifpc", if_id_pc, 32'd0);
    chk("rst_cnt", {16'd0, fetch_count}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    #1 reset = 1'b0;
    model_reset();
    drive(0, 0, 0);
  endtask

  task automatic step(input bit st, input bit br, input logic [31:0] tgt);
    @(negedge clk);
    drive(st, br, tgt);
  endtask

  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
        chk("if_id_instr", if_id_instr, e.instr);
        chk("if_id_pc", if_id_pc, e.ifpc);
        chk("done", {31'd0, done}, {31'd0, e.done});
        chk("fetch_count", {16'd0, fetch_count}, {16'd0, e.cnt});
        chk("imem_addr", {24'd0, imem_addr}, {24'd0, e.pc[7:0]});
      end
    end
  end

  initial begin : stimulus
    int budget;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    model_reset();
    repeat (2) @(negedge clk);

    // straight-line 4-word program then drain
    do_reset(9'd16);
    for (int i = 0; i < 11; i++) step(0, 0, 0);
    @(negedge clk);
    chk("prog16_done", {31'd0, done}, 32'd1);
    chk("prog16_count", {16'd0, fetch_count}, 32'd4);

    // stall at pc 8, then branch+stall from pc 12 to target 3
    do_reset(9'd16);
    step(0, 0, 0);
    step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0);
    step(1, 1, 32'h0000_0003);
    @(negedge clk);
    chk("br_pc", pc_out, 32'd0);
    chk("br_valid", {31'd0, if_id_valid}, 32'd0);
    chk("br_instr", if_id_instr, NOP);
    drive(0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // branch out of DRAIN after 2 drain cycles
    do_reset(9'd16);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    step(0, 1, 32'd4);
    for (int i = 0; i < 10; i++) step(0, 0, 0);

    // reset mid-stall while pc = 8
    do_reset(9'd16);
    step(0, 0, 0);
    step(1, 0, 0);
    do_reset(9'd16);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // empty program; branch in HALTED is ignored
    do_reset(9'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    step(0, 1, 32'd40);
    step(1, 1, 32'd8);

    // randomized programs
    for (int p = 0; p < 24; p++) begin
      logic [8:0] plen;
      case (p)
        0: plen = 9'd0;
        1: plen = 9'd256;
        default: plen = 9'($urandom_range(0, 256));
      endcase
      do_reset(plen);
      budget = 0;
      while (!m_halted && budget < 800) begin
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0),
             32'($urandom_range(0, 300)));
        budget++;
      end
      chk("prog_halts", {31'd0, m_halted}, 32'd1);
      for (int i = 0; i < 3; i++)
        step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
